// File: rtl/b_mem_loader.sv
// rtl/b_mem_loader.sv - programmable bias bank loaded from a word stream, atomic commit
module b_mem_loader #(
  parameter int WIDTH  = 32,
  parameter int N_G_L2 = 3,
  parameter int N_G_L3 = 9,
  parameter int N_D_L2 = 3,
  parameter int N_D_L3 = 1,
  localparam int TOTAL = N_G_L2 + N_G_L3 + N_D_L2 + N_D_L3,
  localparam int CW    = $clog2(TOTAL) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     done,
  output logic [CW-1:0]            word_cnt,
  output logic [N_G_L2*WIDTH-1:0]  bg2,
  output logic [N_G_L3*WIDTH-1:0]  bg3,
  output logic [N_D_L2*WIDTH-1:0]  bd2,
  output logic [N_D_L3*WIDTH-1:0]  bd3
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t state, next_state;
  logic accept;
  logic [WIDTH-1:0] shadow [TOTAL];
  logic [WIDTH-1:0] active [TOTAL];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (in_valid) begin
          accept = 1'b1;
          if (word_cnt == CW'(TOTAL - 1)) next_state = COMMIT;
        end
      end
      COMMIT: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Shadow fills beat by beat; active only ever changes in the single COMMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      done     <= 1'b0;
      for (int i = 0; i < TOTAL; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      done <= (state == COMMIT);
      if (state == IDLE && start) word_cnt <= '0;
      if (accept) begin
        word_cnt <= word_cnt + CW'(1);
        for (int i = 0; i < TOTAL; i++)
          if (word_cnt == CW'(i)) shadow[i] <= in_data;
      end
      if (state == COMMIT)
        for (int i = 0; i < TOTAL; i++) active[i] <= shadow[i];
    end
  end

  for (genvar i = 0; i < N_G_L2; i++) begin : g_bg2
    assign bg2[i*WIDTH +: WIDTH] = active[i];
  end
  for (genvar i = 0; i < N_G_L3; i++) begin : g_bg3
    assign bg3[i*WIDTH +: WIDTH] = active[N_G_L2 + i];
  end
  for (genvar i = 0; i < N_D_L2; i++) begin : g_bd2
    assign bd2[i*WIDTH +: WIDTH] = active[N_G_L2 + N_G_L3 + i];
  end
  for (genvar i = 0; i < N_D_L3; i++) begin : g_bd3
    assign bd3[i*WIDTH +: WIDTH] = active[N_G_L2 + N_G_L3 + N_D_L2 + i];
  end

endmodule

// File: tb/tb_b_mem_loader.sv
// tb/tb_b_mem_loader.sv - directed self-checking bench for b_mem_loader
module tb_b_mem_loader;

  logic         clk = 1'b0;
  logic         rst, start, abort, in_valid;
  logic [31:0]  in_data;
  logic         in_ready, busy, done;
  logic [4:0]   word_cnt;
  logic [95:0]  bg2, bd2;
  logic [287:0] bg3;
  logic [31:0]  bd3;

  int checks = 0;
  int errors = 0;
  logic [31:0] vec [16];

  always #5 clk = ~clk;

  b_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .word_cnt(word_cnt),
    .bg2(bg2), .bg3(bg3), .bd2(bd2), .bd3(bd3)
  );

  function automatic logic [511:0] exp_all();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = vec[i];
    return r;
  endfunction

  function automatic logic [511:0] obs_all();
    return {bd3, bd2, bg3, bg2};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill_vec(input logic [31:0] v);
    for (int i = 0; i < 16; i++) vec[i] = v;
  endtask

  task automatic fill_ref();
    vec[0] = 32'h01A1B252; vec[1] = 32'h00EF368B; vec[2] = 32'h00414304;
    for (int i = 0; i < 9; i++) vec[3+i] = 32'h0B000000 + 32'(i * 32'h00010101);
    vec[12] = 32'h025346EE; vec[13] = 32'h01954545;
    vec[14] = 32'hFEE8EF7B; vec[15] = 32'hFF0ACBCD;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_beats(input int n);
    for (int k = 0; k < n; k++) begin
      in_data = vec[k]; in_valid = 1'b1; tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (obs_all() !== 512'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs_all()); end
    checks++; if ({in_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {in_ready, busy, done}); end
    checks++; if (word_cnt !== 5'd0) begin errors++; $display("FAIL reset_word_cnt got %0d exp 0", word_cnt); end
  endtask

  task automatic test_full_load();
    int busy_cycles = 0;
    fill_ref();
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      if (busy) busy_cycles++;
      in_data = vec[k]; in_valid = 1'b1; tick();
    end
    in_valid = 1'b0;
    checks++; if ({busy, done, word_cnt} !== {2'b10, 5'd16}) begin errors++; $display("FAIL commit_cycle busy/done/cnt got %b/%b/%0d exp 1/0/16", busy, done, word_cnt); end
    if (busy) busy_cycles++;
    tick();
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL full_done done/busy got %b/%b exp 1/0", done, busy); end
    checks++; if (bg2 !== {32'h00414304, 32'h00EF368B, 32'h01A1B252}) begin errors++; $display("FAIL full_bg2 got %h", bg2); end
    checks++; if (bd3 !== 32'hFF0ACBCD) begin errors++; $display("FAIL full_bd3 got %h exp FF0ACBCD", bd3); end
    checks++; if (obs_all() !== exp_all()) begin errors++; $display("FAIL full_all got %h exp %h", obs_all(), exp_all()); end
    checks++; if (busy_cycles !== 17) begin errors++; $display("FAIL full_busy_cycles got %0d exp 17", busy_cycles); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_width got %b exp 0", done); end
  endtask

  task automatic test_bubbles();
    int cnt_bad = 0;
    apply_reset();
    fill_ref();
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      int nb = $urandom_range(0, 2);
      for (int b = 0; b < nb; b++) begin
        in_valid = 1'b0; in_data = $urandom;
        if (word_cnt !== 5'(k)) cnt_bad++;
        tick();
      end
      if (word_cnt !== 5'(k)) cnt_bad++;
      in_data = vec[k]; in_valid = 1'b1; tick();
    end
    in_valid = 1'b0;
    checks++; if (cnt_bad !== 0) begin errors++; $display("FAIL bubble_word_cnt bad samples %0d exp 0", cnt_bad); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bubble_done got %b exp 1", done); end
    checks++; if (obs_all() !== exp_all()) begin errors++; $display("FAIL bubble_all got %h exp %h", obs_all(), exp_all()); end
  endtask

  task automatic test_abort();
    int done_seen = 0;
    fill_vec(32'h00000001);
    pulse_start(); send_beats(16); tick();
    tick();
    fill_vec(32'hFFFFFFFF);
    pulse_start(); send_beats(7);
    in_data = 32'hFFFFFFFF; in_valid = 1'b1; abort = 1'b1; tick();
    in_valid = 1'b0; abort = 1'b0;
    checks++; if ({in_ready, busy, word_cnt} !== {2'b00, 5'd7}) begin errors++; $display("FAIL abort_idle ready/busy/cnt got %b/%b/%0d exp 0/0/7", in_ready, busy, word_cnt); end
    for (int i = 0; i < 4; i++) begin
      if (done) done_seen++;
      tick();
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses exp 0", done_seen); end
    fill_vec(32'h00000001);
    checks++; if (obs_all() !== exp_all()) begin errors++; $display("FAIL abort_outputs got %h exp all 00000001", obs_all()); end
  endtask

  task automatic test_mid_reset();
    fill_vec(32'h5A5A5A5A);
    pulse_start(); send_beats(10);
    apply_reset();
    checks++; if (obs_all() !== 512'd0) begin errors++; $display("FAIL midrst_outputs got %h exp 0", obs_all()); end
    checks++; if ({in_ready, word_cnt} !== 6'd0) begin errors++; $display("FAIL midrst_ready/cnt got %b/%0d exp 0/0", in_ready, word_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) vec[i] = 32'hA0000000 + 32'(i);
    pulse_start(); send_beats(16); tick();
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL b2b_first_done done/busy got %b/%b exp 1/0", done, busy); end
    checks++; if (obs_all() !== exp_all()) begin errors++; $display("FAIL b2b_first_all got %h exp %h", obs_all(), exp_all()); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if ({busy, in_ready, done, word_cnt} !== {3'b110, 5'd0}) begin errors++; $display("FAIL b2b_restart busy/ready/done/cnt got %b/%b/%b/%0d exp 1/1/0/0", busy, in_ready, done, word_cnt); end
    for (int i = 0; i < 16; i++) vec[i] = 32'h80000000 | 32'(i << 8);
    send_beats(16);
    checks++; if (done !== 1'b0 || bg2[31:0] !== 32'hA0000000) begin errors++; $display("FAIL b2b_hold done/bg2_0 got %b/%h exp 0/A0000000", done, bg2[31:0]); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", done); end
    checks++; if (obs_all() !== exp_all()) begin errors++; $display("FAIL b2b_second_all got %h exp %h", obs_all(), exp_all()); end
    tick();
  endtask

  task automatic test_ignored();
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if ({busy, in_ready} !== 2'b00) begin errors++; $display("FAIL idle_abort busy/ready got %b/%b exp 0/0", busy, in_ready); end
    for (int i = 0; i < 16; i++) vec[i] = 32'h12340000 + 32'(i * 3);
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      in_data = vec[k]; in_valid = 1'b1; start = (k == 5); tick();
    end
    in_valid = 1'b0; start = 1'b0;
    checks++; if (word_cnt !== 5'd16) begin errors++; $display("FAIL load_start_ignored cnt got %0d exp 16", word_cnt); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignored_done got %b exp 1", done); end
    checks++; if (obs_all() !== exp_all()) begin errors++; $display("FAIL ignored_all got %h exp %h", obs_all(), exp_all()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_full_load();
    test_bubbles();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    test_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/b_mem_loader.md
Name: b_mem_loader

Overview:
- Writer counterpart to the fixed bias ROM: a programmable bias register bank loaded at run time from a 32-bit valid/ready word stream.
- Presents the same flattened bias buses (bg2, bg3, bd2, bd3) to the generator and discriminator datapaths.
- Loads into shadow registers and commits atomically, so consumers never see a partially updated bias set.
- Data format is signed Q8.24 (32'h01000000 = 1.0). The loader passes words through unchanged.

Parameters:
- WIDTH, 32, bias word width in bits.
- N_G_L2, 3, generator layer-2 bias count.
- N_G_L3, 9, generator layer-3 bias count.
- N_D_L2, 3, discriminator layer-2 bias count.
- N_D_L3, 1, discriminator layer-3 bias count.
- Derived: TOTAL = N_G_L2 + N_G_L3 + N_D_L2 + N_D_L3 (16 by default).
- Derived: CW = clog2(TOTAL) + 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- abort  in  1  cancels a load in progress; honoured only in LOAD.
- in_data  in  WIDTH  bias word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a word this cycle.
- busy  out  1  high in LOAD and COMMIT.
- done  out  1  one-cycle pulse; new bias set is visible on the outputs.
- word_cnt  out  CW  number of words accepted in the current load.
- bg2  out  N_G_L2*WIDTH  active biases; element i at bits [i*WIDTH +: WIDTH].
- bg3  out  N_G_L3*WIDTH  same packing.
- bd2  out  N_D_L2*WIDTH  same packing.
- bd3  out  N_D_L3*WIDTH  same packing.

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE; word_cnt=0; in_ready=0; busy=0; done=0.
  - All shadow and active registers are cleared to 0.
  - Reset overrides every other input, including mid-load and during COMMIT.
- Stream order (beat k = k-th accepted word):
  - Beats 0..2 go to bg2[0..2].
  - Beats 3..11 go to bg3[0..8].
  - Beats 12..14 go to bd2[0..2].
  - Beat 15 goes to bd3[0].
  - The general rule follows the same sequence using the parameter counts.
- FSM state IDLE:
  - in_ready=0.
  - If start=1: go to LOAD and set word_cnt to 0.
  - abort is ignored.
- FSM state LOAD:
  - in_ready=1 combinationally from the state, not dependent on in_valid.
  - A beat is accepted when in_valid && in_ready && !abort.
  - On acceptance, shadow[word_cnt] <= in_data and word_cnt increments.
  - When the accepted beat is the last (word_cnt == TOTAL-1), go to COMMIT; word_cnt becomes TOTAL.
  - If abort=1: go to IDLE. abort takes priority over a same-cycle valid beat, which is dropped. Shadow contents are discarded, active outputs are unchanged, and done is not asserted.
  - start is ignored.
  - in_valid gaps (bubbles) are allowed anywhere in the stream with no timeout.
- FSM state COMMIT (exactly one cycle):
  - in_ready=0; busy=1.
  - At the closing edge, all active registers load from shadow in the same edge, done is registered to 1, and the FSM goes to IDLE.
  - abort and start are ignored.
- done behaviour:
  - done is high for exactly the one cycle after COMMIT.
  - The new bias values are visible in that same cycle.
  - A start in that cycle is accepted (back-to-back loads are allowed).
- Latency: with the last beat accepted at edge E, the outputs update and done=1 from edge E+1 onward (one COMMIT cycle).
- Active outputs hold their values indefinitely between commits. A new load leaves the active outputs unchanged until its own COMMIT.
- No arithmetic is performed. Words are stored bit-exact, with no sign extension or saturation.

Test Plan:
- Reset, then load 16 beats with no bubbles: 01A1B252, 00EF368B, 00414304, then the nine bg3 words, then 025346EE, 01954545, FEE8EF7B, FF0ACBCD.
  - Required: bg2 = {00414304, 00EF368B, 01A1B252}; bd3 = FF0ACBCD.
  - Required: done is high exactly one cycle, 1 cycle after the last beat; busy is high for 17 cycles.
- Same load with random in_valid bubbles → identical outputs; word_cnt increments only on accepted beats.
- Complete load A (all 32'h00000001), then start load B (all 32'hFFFFFFFF) and abort after 7 beats.
  - Required: outputs remain all 00000001; no done pulse; FSM returns to IDLE; the abort-cycle beat is dropped.
- Mid-load reset after 10 beats → all outputs 0, in_ready=0, word_cnt=0.
- start asserted in the done cycle, followed by a second 16-beat load → second set committed; each load produces one done pulse.
- start pulsed during LOAD, and abort pulsed in IDLE → both ignored; the in-flight load completes normally.
